// File: rtl/regfile_client.sv
// regfile_client: operand-fetch front end for a register file with registered reads.
// Takes an rs/rt read request, presents the addresses, and folds in any write that
// commits while the read is in flight, so a response always reflects the newest value.
module regfile_client #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rf_rs_addr,
    output logic [ADDR_W-1:0] rf_rt_addr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t            state, state_nxt;
    logic              hit_rs, hit_rt;
    logic              fwd_rs, fwd_rt;
    logic [DATA_W-1:0] fwd_data;

    // Writes go straight through; reset masks the enable so nothing commits while held.
    assign rf_we      = wr_en & rst_n;
    assign rf_rd_addr = wr_addr;
    assign rf_wdata   = wr_data;

    // A write committing at the coming edge that targets one of the held read addresses.
    assign hit_rs = rf_we && (wr_addr == rf_rs_addr);
    assign hit_rt = rf_we && (wr_addr == rf_rt_addr);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; handshakes are masked while reset is held.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP: begin
                rsp_valid = rst_n;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: address latch, forward capture at the file's sampling edge, operand
    // selection, and in-place refresh while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_rs_addr <= '0;
            rf_rt_addr <= '0;
            rs_data    <= '0;
            rt_data    <= '0;
            fwd_rs     <= 1'b0;
            fwd_rt     <= 1'b0;
            fwd_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        rf_rs_addr <= req_rs;
                        rf_rt_addr <= req_rt;
                    end
                end
                ISSUE: begin
                    // The file samples the old contents at this edge, so a same-edge
                    // write has to be remembered here and applied one edge later.
                    fwd_rs   <= hit_rs;
                    fwd_rt   <= hit_rt;
                    fwd_data <= wr_data;
                end
                CAPTURE: begin
                    rs_data <= hit_rs ? wr_data : (fwd_rs ? fwd_data : rf_rs_data);
                    rt_data <= hit_rt ? wr_data : (fwd_rt ? fwd_data : rf_rt_data);
                end
                RESP: begin
                    if (!rsp_ready) begin
                        if (hit_rs) rs_data <= wr_data;
                        if (hit_rt) rt_data <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/regfile_client.md
REGFILE_CLIENT -- requirements
Module: regfile_client

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 6, register address width (64 entries); DATA_W, default 32, register data width.
REQ-002 Port clk, input, 1: single clock; every state element updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-004 Port req_valid, input, 1: operand-fetch request valid.
REQ-005 Port req_ready, output, 1: block can accept a request.
REQ-006 Ports req_rs and req_rt, input, ADDR_W each: operand addresses to read.
REQ-007 Port rsp_valid, output, 1: operand data valid.
REQ-008 Port rsp_ready, input, 1: consumer accepts operand data.
REQ-009 Ports rs_data and rt_data, output, DATA_W each: operand values.
REQ-010 Ports wr_en (1), wr_addr (ADDR_W), wr_data (DATA_W), input: write request.
REQ-011 Ports rf_rs_addr and rf_rt_addr, output, ADDR_W each: read addresses to the register file.
REQ-012 Ports rf_we (1), rf_rd_addr (ADDR_W), rf_wdata (DATA_W), output: write port to the register file.
REQ-013 Ports rf_rs_data and rf_rt_data, input, DATA_W each: register file read data, registered by the file one edge after it samples the address.

Function
REQ-014 The write path SHALL be combinational pass-through: rf_we = wr_en & rst_n, rf_rd_addr = wr_addr, rf_wdata = wr_data; a write commits at the edge where rf_we is high.
REQ-015 Writes SHALL always be accepted, independent of FSM state.
REQ-016 The FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-018 IDLE->ISSUE at an edge with req_valid=1: latch req_rs/req_rt into rf_rs_addr/rf_rt_addr.
REQ-019 ISSUE->CAPTURE unconditionally, and latch into a forward register whether the write committed at this edge matches rs and/or rt, plus its data.
REQ-020 CAPTURE->RESP unconditionally, and load rs_data from the highest-priority source: a write matching at this edge, else the forward register from REQ-019, else rf_rs_data; rt_data follows the same rule.
REQ-021 In RESP, at each edge without a handshake, a committing write whose address matches rf_rs_addr (rf_rt_addr) SHALL replace rs_data (rt_data).
REQ-022 RESP->IDLE at an edge with rsp_ready=1; outputs hold while rsp_ready=0.
REQ-023 Invariant: in every RESP cycle, rs_data and rt_data SHALL equal the architectural register value including every write committed up to the previous edge.
REQ-024 rs==rt SHALL return identical values in both outputs.
REQ-025 Latency: request accepted at edge E0 gives rsp_valid=1 in the cycle after E0+2; back-to-back throughput is one request per 4 cycles when rsp_ready=1.
REQ-026 rf_rs_addr and rf_rt_addr SHALL hold stable from ISSUE through RESP.

Reset
REQ-027 At an edge with rst_n=0, the FSM SHALL go to IDLE; rs_data, rt_data, rf_rs_addr and rf_rt_addr SHALL clear to 0; the forward register SHALL clear.
REQ-028 During reset, rsp_valid and req_ready SHALL be 0 and rf_we SHALL be 0; any in-flight request SHALL be dropped with no response.
REQ-029 At the first edge with rst_n=1, the block SHALL be in IDLE with req_ready=1.

Verification
REQ-030 Write r5=0x11 at edge E, then request rs=5/rt=6 (r6=0x22) -> rsp_valid after E0+2 with rs_data=0x11, rt_data=0x22.
REQ-031 Request rs=7 (r7=0xA) with a write of r7=0xB at the ISSUE edge -> rs_data=0xB (forward path).
REQ-032 Request rs=7 with a write of r7=0xC at the CAPTURE edge -> rs_data=0xC.
REQ-033 Hold rsp_ready=0 for 3 cycles while writing r7=0xD -> rs_data changes to 0xD the next cycle and rsp_valid stays 1; handshake -> IDLE.
REQ-034 Request rs=rt=9 -> both outputs are equal; a non-matching write to r10 does not alter the response.
REQ-035 Assert rst_n=0 during CAPTURE with wr_en=1 -> no rsp_valid, rf_we=0, outputs 0, and req_ready=1 one edge after release.
